// File: rtl/vga_scanout_pkg.sv
// rtl/vga_scanout_pkg.sv - shared VGA timing constants, colour/address types and helpers
package vga_scanout_pkg;

  // 640x480@60 Hz timing, counted in pixels and lines
  localparam int VGA_CLK_DIV   = 2;
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Colour is packed {R[3:0], G[3:0], B[3:0]}
  localparam int RGB_W = 12;
  localparam logic [RGB_W-1:0] VGA_FG_COLOR = 12'hFFF;
  localparam logic [RGB_W-1:0] VGA_BG_COLOR = 12'h000;

  // Framebuffer is 640x480 one-bit pixels
  localparam int ADDR_W = 19;

  // Pixel and line counters share one width; 10 bits covers 800 and 525
  localparam int CNT_W = 10;

  typedef logic [RGB_W-1:0]  rgb_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Everything the display sees, loaded together once per pixel
  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    rgb_t rgb;
  } out_reg_t;

  localparam out_reg_t OUT_RESET = '{hsync_n: 1'b1, vsync_n: 1'b1, rgb: '0};

  // Multiply a counter by a constant as a sum of shifted copies, one per set bit
  // of k; with k constant this folds into a few adders instead of a multiplier.
  function automatic addr_t mul_const(input logic [CNT_W-1:0] a, input int unsigned k);
    addr_t acc;
    acc = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (k[i]) begin
        acc = acc + (addr_t'(a) << i);
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel divider, h/v counters, visible/sync decode and frame strobe
module vga_timing
  import vga_scanout_pkg::*;
#(
  parameter int CLK_DIV   = VGA_CLK_DIV,
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic             clk,
  input  logic             reset,
  output logic             tick_o,
  output logic [CNT_W-1:0] h_count_o,
  output logic [CNT_W-1:0] v_count_o,
  output logic             visible_o,
  output logic             hsync_n_o,
  output logic             vsync_n_o,
  output logic             frame_start_o,
  output logic             in_vblank_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_END    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_END    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             tick;
  logic             h_last;
  logic             v_last;

  // One tick per pixel period, on the last core clock of the period
  assign tick   = (div_q == DIV_LAST);
  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);

  // Next-state for the divider and the raster position
  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Divider and raster position registers; reset lands on the top-left pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign tick_o        = tick;
  assign h_count_o     = h_q;
  assign v_count_o     = v_q;
  assign visible_o     = (h_q < H_VIS_END) && (v_q < V_VIS_END);
  assign hsync_n_o     = !((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
  assign vsync_n_o     = !((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
  // Only a full raster wrap counts, so reset never produces a stray strobe
  assign frame_start_o = tick && h_last && v_last;
  assign in_vblank_o   = (v_q >= V_VIS_END);

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA scanout: framebuffer addressing and registered colour/sync stage
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int         CLK_DIV   = VGA_CLK_DIV,
  parameter int         H_VISIBLE = VGA_H_VISIBLE,
  parameter int         H_FRONT   = VGA_H_FRONT,
  parameter int         H_SYNC    = VGA_H_SYNC,
  parameter int         H_BACK    = VGA_H_BACK,
  parameter int         V_VISIBLE = VGA_V_VISIBLE,
  parameter int         V_FRONT   = VGA_V_FRONT,
  parameter int         V_SYNC    = VGA_V_SYNC,
  parameter int         V_BACK    = VGA_V_BACK,
  parameter logic [11:0] FG_COLOR = VGA_FG_COLOR,
  parameter logic [11:0] BG_COLOR = VGA_BG_COLOR
) (
  input  logic        clk,
  input  logic        reset,
  output logic [18:0] pixelAddr,
  input  logic        pixelIn,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        frameStart,
  output logic        inVblank
);

  logic             tick;
  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             visible;
  logic             hsync_n;
  logic             vsync_n;
  out_reg_t         out_q, out_d;

  vga_timing #(
    .CLK_DIV  (CLK_DIV),
    .H_VISIBLE(H_VISIBLE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_VISIBLE(V_VISIBLE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) u_timing (
    .clk          (clk),
    .reset        (reset),
    .tick_o       (tick),
    .h_count_o    (h_count),
    .v_count_o    (v_count),
    .visible_o    (visible),
    .hsync_n_o    (hsync_n),
    .vsync_n_o    (vsync_n),
    .frame_start_o(frameStart),
    .in_vblank_o  (inVblank)
  );

  // Row-major address of the current pixel; parked at 0 while blanked
  assign pixelAddr = visible ? (mul_const(v_count, H_VISIBLE) + ADDR_W'(h_count)) : '0;

  // At the end of each pixel period capture sync and colour for the position
  // just shown. The framebuffer answered during that period, so pixelIn is
  // settled; outside the visible area it is ignored so an undriven bus cannot
  // leak onto the DAC.
  always_comb begin
    out_d = out_q;
    if (tick) begin
      out_d.hsync_n = hsync_n;
      out_d.vsync_n = vsync_n;
      out_d.rgb     = visible ? (pixelIn ? FG_COLOR : BG_COLOR) : '0;
    end
  end

  // Output register, one pixel behind the raster counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= OUT_RESET;
    end else begin
      out_q <= out_d;
    end
  end

  assign hSync = out_q.hsync_n;
  assign vSync = out_q.vsync_n;
  assign VGA_R = out_q.rgb[11:8];
  assign VGA_G = out_q.rgb[7:4];
  assign VGA_B = out_q.rgb[3:0];

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - scoreboard bench for vga_scanout at full and reduced timing
module tb_vga_scanout;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // A: default 640x480 timing; B: 8x6 raster (16x11 total), CLK_DIV 2;
  // C: same small raster with CLK_DIV 4 and green foreground
  logic [18:0] a_addr, b_addr, c_addr;
  logic        a_hs, a_vs, a_fs, a_vb, b_hs, b_vs, b_fs, b_vb, c_hs, c_vs, c_fs, c_vb;
  logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
  logic        pa = 1'bx, pb = 1'b1, pc = 1'b1;
  logic [11:0] a_rgb, b_rgb, c_rgb;
  assign a_rgb = {a_r, a_g, a_b};
  assign b_rgb = {b_r, b_g, b_b};
  assign c_rgb = {c_r, c_g, c_b};

  vga_scanout u_a (
    .clk(clk), .reset(reset), .pixelAddr(a_addr), .pixelIn(pa), .hSync(a_hs), .vSync(a_vs),
    .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b), .frameStart(a_fs), .inVblank(a_vb));

  vga_scanout #(.CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)) u_b (
    .clk(clk), .reset(reset), .pixelAddr(b_addr), .pixelIn(pb), .hSync(b_hs), .vSync(b_vs),
    .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .frameStart(b_fs), .inVblank(b_vb));

  vga_scanout #(.CLK_DIV(4), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .FG_COLOR(12'h0F0)) u_c (
    .clk(clk), .reset(reset), .pixelAddr(c_addr), .pixelIn(pc), .hSync(c_hs), .vSync(c_vs),
    .VGA_R(c_r), .VGA_G(c_g), .VGA_B(c_b), .frameStart(c_fs), .inVblank(c_vb));

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int win_a, win_b, win_c;
  bit armed = 1'b0;
  int exp_sb[int];

  // Clock edges since reset release; the first posedge after release is 1
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Framebuffer models: A has a single set bit at 641, B is all ones,
  // C is all ones but undriven during vertical blanking
  always @(negedge clk) begin
    pa = reset ? 1'bx : (a_addr == 19'd641);
    pb = 1'b1;
    pc = c_vb ? 1'bx : 1'b1;
  end

  function automatic string kname(input int k);
    case (k)
      1: return "a_hsync_fall";  2: return "a_hsync_rise";
      3: return "a_addr641";     4: return "a_rgb_on";     5: return "a_rgb_off";
      11: return "b_hsync_fall"; 12: return "b_hsync_rise";
      13: return "b_vsync_fall"; 14: return "b_vsync_rise";
      15: return "b_frame_start";
      16: return "b_vblank_rise"; 17: return "b_vblank_fall";
      18: return "b_rgb_on";     19: return "b_addr47";    20: return "b_rgb_off";
      21: return "c_hsync_fall"; 22: return "c_rgb_on";
      default: return "unknown";
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int c, input int val, input int win);
    if (c <= win) exp_sb[kind * 1000000 + c] = val;
  endtask

  task automatic observe(input int kind, input int c, input int val);
    int key;
    key = kind * 1000000 + c;
    n_cmp++;
    if (!exp_sb.exists(key)) begin
      n_err++;
      $display("FAIL %s: unexpected event at clk %0d (value %0h)", kname(kind), c, val);
    end else begin
      if (exp_sb[key] != val) begin
        n_err++;
        $display("FAIL %s: at clk %0d got %0h, expected %0h", kname(kind), c, val, exp_sb[key]);
      end
      exp_sb.delete(key);
    end
  endtask

  task automatic finalize();
    foreach (exp_sb[k]) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no event at clk %0d, expected value %0h", kname(k / 1000000), k % 1000000, exp_sb[k]);
    end
    exp_sb.delete();
  endtask

  // Hand-computed event times: pixel period n ends at clk n*CLK_DIV and the
  // outputs then show the position held during that period (one pixel lag).
  task automatic push_all();
    for (int i = 0; i < 3; i++) begin
      push(1, 1314 + 1600 * i, 1, win_a);
      push(2, 1506 + 1600 * i, 1, win_a);
    end
    push(3, 1602, 1, win_a);
    push(4, 1604, 12'hFFF, win_a);
    push(5, 1606, 1, win_a);
    for (int i = 0; i < 23; i++) begin
      push(11, 22 + 32 * i, 1, win_b);
      push(12, 28 + 32 * i, 1, win_b);
      push(21, 44 + 64 * i, 1, win_c);
    end
    for (int f = 0; f < 3; f++) begin
      push(13, 226 + 352 * f, 1, win_b);
      push(14, 290 + 352 * f, 1, win_b);
      push(15, 351 + 352 * f, 1, win_b);
      push(16, 192 + 352 * f, 1, win_b);
      push(17, 352 + 352 * f, 1, win_b);
      push(19, 174 + 352 * f, 1, win_b);
      for (int v = 0; v < 6; v++) begin
        push(18, 352 * f + 32 * v + 2, 12'hFFF, win_b);
        push(20, 352 * f + 32 * v + 18, 1, win_b);
        push(22, 704 * f + 64 * v + 4, 12'h0F0, win_c);
      end
    end
  endtask

  // Monitor: turns output transitions into events and checks them off the scoreboard
  logic        pa_hs = 1'b1, pb_hs = 1'b1, pb_vs = 1'b1, pb_vb = 1'b0, pc_hs = 1'b1;
  logic [11:0] pa_rgb = '0, pb_rgb = '0, pc_rgb = '0;
  logic [18:0] pa_addr = '0, pb_addr = '0;
  always @(negedge clk) begin
    if (!reset && armed) begin
      if (cyc <= win_a) begin
        if (pa_hs && !a_hs) observe(1, cyc, 1);
        if (!pa_hs && a_hs) observe(2, cyc, 1);
        if (a_addr == 19'd641 && pa_addr != 19'd641) observe(3, cyc, 1);
        if (a_rgb != 0 && pa_rgb == 0) observe(4, cyc, int'(a_rgb));
        if (a_rgb == 0 && pa_rgb != 0) observe(5, cyc, 1);
        if (!a_vs || a_fs || a_vb) observe(0, cyc, {a_vs, a_fs, a_vb});
      end
      if (cyc <= win_b) begin
        if (pb_hs && !b_hs) observe(11, cyc, 1);
        if (!pb_hs && b_hs) observe(12, cyc, 1);
        if (pb_vs && !b_vs) observe(13, cyc, 1);
        if (!pb_vs && b_vs) observe(14, cyc, 1);
        if (b_fs) observe(15, cyc, 1);
        if (!pb_vb && b_vb) observe(16, cyc, 1);
        if (pb_vb && !b_vb) observe(17, cyc, 1);
        if (b_rgb != 0 && pb_rgb == 0) observe(18, cyc, int'(b_rgb));
        if (b_addr == 19'd47 && pb_addr != 19'd47) observe(19, cyc, 1);
        if (b_rgb == 0 && pb_rgb != 0) observe(20, cyc, 1);
      end
      if (cyc <= win_c) begin
        if (pc_hs && !c_hs) observe(21, cyc, 1);
        if (c_rgb != 0 && pc_rgb == 0) observe(22, cyc, int'(c_rgb));
      end
    end
    pa_hs = a_hs; pa_rgb = a_rgb; pa_addr = a_addr;
    pb_hs = b_hs; pb_vs = b_vs; pb_vb = b_vb; pb_rgb = b_rgb; pb_addr = b_addr;
    pc_hs = c_hs; pc_rgb = c_rgb;
  end

  initial begin
    win_a = 4700;
    win_b = 720;
    win_c = 1420;
    repeat (10) @(negedge clk);
    check("rst_a_hsync", int'(a_hs), 1);
    check("rst_a_vsync", int'(a_vs), 1);
    check("rst_a_rgb", int'(a_rgb), 0);
    check("rst_a_frame_start", int'(a_fs), 0);
    check("rst_a_addr", int'(a_addr), 0);
    check("rst_a_vblank", int'(a_vb), 0);
    check("rst_b_rgb", int'(b_rgb), 0);
    check("rst_c_hsync", int'(c_hs), 1);

    push_all();
    armed = 1'b1;
    #2 reset = 1'b0;
    while (cyc < 4710) @(negedge clk);

    // Async reset between clock edges while B is showing a lit pixel
    for (int t = 0; t < 200 && b_rgb == 0; t++) @(negedge clk);
    check("b_lit_before_reset", int'(b_rgb != 0), 1);
    #2 reset = 1'b1;
    #1;
    check("async_b_rgb", int'(b_rgb), 0);
    check("async_b_addr", int'(b_addr), 0);
    check("async_b_hsync", int'(b_hs), 1);
    check("async_b_vsync", int'(b_vs), 1);
    check("async_b_frame_start", int'(b_fs), 0);
    check("async_c_rgb", int'(c_rgb), 0);
    finalize();

    // Restart from reset: B must resume from the top-left pixel on schedule
    win_a = 0;
    win_b = 40;
    win_c = 0;
    push_all();
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    while (cyc < 45) @(negedge clk);
    finalize();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
